// File: rtl/exposure_pkg.sv
// rtl/exposure_pkg.sv - shared types and default constants for the exposure control path
package exposure_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DELAY,
        REPEAT
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        INC,
        DEC
    } dir_e;

    localparam int DEF_W             = 5;
    localparam int DEF_MIN_TIME      = 2;
    localparam int DEF_MAX_TIME      = 30;
    localparam int DEF_DEFAULT_TIME  = 2;
    localparam int DEF_STEP          = 1;
    localparam int DEF_REPEAT_DELAY  = 8;
    localparam int DEF_REPEAT_PERIOD = 4;

endpackage

// File: rtl/exposure_time_ctrl_button_repeat.sv
// rtl/exposure_time_ctrl_button_repeat.sv - up/down button qualifier with hold-to-auto-repeat
module button_repeat
    import exposure_pkg::*;
#(
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic up_i,
    input  logic down_i,
    output logic step_o,
    output dir_e dir_o
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

    state_e          state_q, state_d;
    dir_e            dir_q, dir_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            step_q, step_d;
    dir_e            in_dir;

    assign in_dir = (up_i ^ down_i) ? (up_i ? INC : DEC) : NONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= NONE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

    // A release or a change of direction always drops back to IDLE; the new
    // direction is then taken as a fresh press on the following cycle.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        if (in_dir == NONE || (state_q != IDLE && in_dir != dir_q)) begin
            state_d = IDLE;
            dir_d   = NONE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    step_d  = 1'b1;
                    state_d = HOLD_DELAY;
                    dir_d   = in_dir;
                    cnt_d   = '0;
                end
                HOLD_DELAY: begin
                    if (cnt_q == DELAY_LAST) begin
                        step_d  = 1'b1;
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (cnt_q == PERIOD_LAST) begin
                        step_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dir_d   = NONE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign step_o = step_q;
    assign dir_o  = dir_q;

endmodule

// File: rtl/exposure_time_ctrl.sv
// rtl/exposure_time_ctrl.sv - saturating exposure-time register with lock deferral and status flags
module exposure_time_ctrl
    import exposure_pkg::*;
#(
    parameter int W             = DEF_W,
    parameter int MIN_TIME      = DEF_MIN_TIME,
    parameter int MAX_TIME      = DEF_MAX_TIME,
    parameter int DEFAULT_TIME  = DEF_DEFAULT_TIME,
    parameter int STEP          = DEF_STEP,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Exp_increase,
    input  logic         Exp_decrease,
    input  logic         Lock,
    output logic [W-1:0] EX_time,
    output logic         At_min,
    output logic         At_max,
    output logic         Changed
);

    localparam logic [W-1:0] MIN_V  = W'(MIN_TIME);
    localparam logic [W-1:0] MAX_V  = W'(MAX_TIME);
    localparam logic [W-1:0] DEF_V  = W'(DEFAULT_TIME);
    localparam logic [W-1:0] STEP_V = W'(STEP);
    localparam logic [W:0]   MAX_X  = (W+1)'(MAX_TIME);
    localparam logic [W:0]   DEC_LO = (W+1)'(MIN_TIME + STEP);

    logic         req;
    dir_e         req_dir;
    logic         lock_q;
    dir_e         pend_q, pend_d;
    dir_e         apply_dir;
    logic [W-1:0] ex_q, ex_d;
    logic         changed_q, changed_d;
    logic         at_min_q, at_max_q;
    logic [W:0]   inc_sum;

    button_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_button_repeat (
        .clk    (Clk),
        .reset  (Reset),
        .up_i   (Exp_increase),
        .down_i (Exp_decrease),
        .step_o (req),
        .dir_o  (req_dir)
    );

    assign inc_sum = {1'b0, ex_q} + {1'b0, STEP_V};

    // Lock is registered so it lines up with the registered step request.
    always_comb begin
        apply_dir = NONE;
        pend_d    = pend_q;
        if (lock_q) begin
            if (req) pend_d = req_dir;
        end else if (pend_q != NONE) begin
            apply_dir = pend_q;
            pend_d    = req ? req_dir : NONE;
        end else if (req) begin
            apply_dir = req_dir;
        end

        ex_d = ex_q;
        case (apply_dir)
            INC:     ex_d = (inc_sum > MAX_X) ? MAX_V : (ex_q + STEP_V);
            DEC:     ex_d = ({1'b0, ex_q} < DEC_LO) ? MIN_V : (ex_q - STEP_V);
            default: ex_d = ex_q;
        endcase
        changed_d = (ex_d != ex_q);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lock_q    <= 1'b0;
            pend_q    <= NONE;
            ex_q      <= DEF_V;
            changed_q <= 1'b0;
            at_min_q  <= (DEF_V == MIN_V);
            at_max_q  <= (DEF_V == MAX_V);
        end else begin
            lock_q    <= Lock;
            pend_q    <= pend_d;
            ex_q      <= ex_d;
            changed_q <= changed_d;
            at_min_q  <= (ex_d == MIN_V);
            at_max_q  <= (ex_d == MAX_V);
        end
    end

    assign EX_time = ex_q;
    assign At_min  = at_min_q;
    assign At_max  = at_max_q;
    assign Changed = changed_q;

endmodule

// File: tb/tb_exposure_time_ctrl.sv
// tb/tb_exposure_time_ctrl.sv - directed self-checking bench for exposure_time_ctrl
module tb_exposure_time_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Exp_increase = 1'b0;
    logic       Exp_decrease = 1'b0;
    logic       Lock = 1'b0;
    logic [4:0] EX_time;
    logic       At_min, At_max, Changed;

    int errors = 0;
    int checks = 0;

    exposure_time_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Exp_increase (Exp_increase),
        .Exp_decrease (Exp_decrease),
        .Lock         (Lock),
        .EX_time      (EX_time),
        .At_min       (At_min),
        .At_max       (At_max),
        .Changed      (Changed)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input logic inc);
        if (inc) Exp_increase = 1'b1; else Exp_decrease = 1'b1;
        tick();
        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        bit exp_step;

        // Reset
        Reset = 1'b1;
        tick();
        tick();
        chk("rst_ex", EX_time, 2);
        chk("rst_min", At_min, 1);
        chk("rst_max", At_max, 0);
        chk("rst_chg", Changed, 0);
        Reset = 1'b0;
        tick();

        // Single increase pulses
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1);
            chk("inc_ex", EX_time, 3 + i);
            chk("inc_chg", Changed, 1);
            tick();
            chk("inc_chg_off", Changed, 0);
        end
        chk("inc_min", At_min, 0);

        // Single decrease pulses
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0);
            chk("dec_ex", EX_time, 5 - i);
            chk("dec_chg", Changed, 1);
            tick();
        end
        chk("dec_min", At_min, 1);

        // Decrease at lower bound
        pulse(1'b0);
        chk("sat_lo_ex", EX_time, 2);
        chk("sat_lo_chg", Changed, 0);
        tick();
        chk("sat_lo_chg2", Changed, 0);
        tick();

        // Auto-repeat: hold 40 sampled edges
        Exp_increase = 1'b1;
        for (int n = 0; n < 45; n++) begin
            tick();
            if (n == 39) Exp_increase = 1'b0;
            exp_step = (n == 1) || (n >= 9 && n <= 37 && ((n - 9) % 4) == 0);
            chk($sformatf("rpt_chg_n%0d", n), Changed, int'(exp_step));
        end
        chk("rpt_ex", EX_time, 11);

        // Walk up to 28 with single pulses
        for (int i = 0; i < 17; i++) begin
            pulse(1'b1);
            tick();
        end
        chk("pre_sat_ex", EX_time, 28);

        // Upper saturation under hold
        pulses = 0;
        Exp_increase = 1'b1;
        for (int n = 0; n < 21; n++) begin
            tick();
            if (Changed) pulses++;
            if (n == 1) chk("sat_hi_29", EX_time, 29);
            if (n == 9) chk("sat_hi_30", EX_time, 30);
        end
        Exp_increase = 1'b0;
        chk("sat_hi_ex", EX_time, 30);
        chk("sat_hi_max", At_max, 1);
        chk("sat_hi_pulses", pulses, 2);
        tick();
        tick();

        // Lock: inc then dec while locked, latest wins
        Lock = 1'b1;
        tick();
        pulse(1'b1);
        pulse(1'b0);
        tick();
        tick();
        chk("lock_hold_ex", EX_time, 30);
        chk("lock_hold_chg", Changed, 0);
        Lock = 1'b0;
        tick();
        chk("unlock_m_ex", EX_time, 30);
        tick();
        chk("unlock_ex", EX_time, 29);
        chk("unlock_chg", Changed, 1);
        chk("unlock_max", At_max, 0);
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (Changed) pulses++;
        end
        chk("unlock_once", pulses, 0);
        chk("unlock_ex2", EX_time, 29);

        // Both buttons together
        Exp_increase = 1'b1;
        Exp_decrease = 1'b1;
        pulses = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (Changed) pulses++;
        end
        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;
        chk("both_ex", EX_time, 29);
        chk("both_chg", pulses, 0);
        tick();

        // Reset mid-repeat with pending step
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        chk("mid_pre_ex", EX_time, 2);
        Exp_increase = 1'b1;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (n == 9) Lock = 1'b1;
        end
        chk("mid_locked_ex", EX_time, 4);
        Reset = 1'b1;
        Exp_increase = 1'b0;
        tick();
        chk("mid_rst_ex", EX_time, 2);
        chk("mid_rst_min", At_min, 1);
        Reset = 1'b0;
        Lock = 1'b0;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (Changed) pulses++;
        end
        chk("mid_after_ex", EX_time, 2);
        chk("mid_after_chg", pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
